// File: rtl/pcie_axis_tx_arbiter.sv
// ----------------------------------------------------------------------------
// pcie_axis_tx_arbiter
//
// Packet-atomic round-robin arbiter that merges NUM_CH AXI-stream TLP sources
// (DMA, completer, MSI, ...) onto the single endpoint TX stream. A channel is
// granted only between packets and keeps the stream until its tlast beat is
// accepted. The merged stream leaves through a one-deep registered output
// stage. New grants are blocked while user_lnk_up is low; a packet already in
// flight still completes.
//
// Optional feature macro: PCIE_TX_ARB_PKT_CNT_EN
//   defined   -> per-channel 16-bit sent-packet counters on pkt_cnt
//   undefined -> pkt_cnt is tied to zero and no counter flops exist
//
// Ports
//   sys_clk_n         in   sole clock, rising edge active
//   sys_rst_n         in   synchronous active-low reset
//   user_lnk_up       in   link status; 0 blocks new grants
//   s_axis_tx_tdata   in   NUM_CH*DATA_W, channel c at [c*DATA_W +: DATA_W]
//   s_axis_tx_tkeep   in   NUM_CH*KEEP_W per-channel byte enables
//   s_axis_tx_tuser   in   NUM_CH*USER_W per-channel sideband
//   s_axis_tx_tlast   in   NUM_CH end-of-TLP flags
//   s_axis_tx_tvalid  in   NUM_CH valids
//   s_axis_tx_tready  out  NUM_CH readies, at most one bit set
//   m_axis_tx_t*      out  merged, registered stream (tready is an input)
//   grant_id          out  currently or last granted channel
//   busy              out  1 while a packet owns the stream
//   pkt_cnt           out  NUM_CH*16 sent-packet counters
// ----------------------------------------------------------------------------
module pcie_axis_tx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 256,
  parameter int USER_W = 4,
  parameter int CH_W   = 2,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic                     sys_clk_n,
  input  logic                     sys_rst_n,
  input  logic                     user_lnk_up,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tx_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_axis_tx_tkeep,
  input  logic [NUM_CH*USER_W-1:0] s_axis_tx_tuser,
  input  logic [NUM_CH-1:0]        s_axis_tx_tlast,
  input  logic [NUM_CH-1:0]        s_axis_tx_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tx_tready,
  output logic [DATA_W-1:0]        m_axis_tx_tdata,
  output logic [KEEP_W-1:0]        m_axis_tx_tkeep,
  output logic [USER_W-1:0]        m_axis_tx_tuser,
  output logic                     m_axis_tx_tlast,
  output logic                     m_axis_tx_tvalid,
  input  logic                     m_axis_tx_tready,
  output logic [CH_W-1:0]          grant_id,
  output logic                     busy,
  output logic [NUM_CH*16-1:0]     pkt_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
  logic [USER_W-1:0]   out_user_q, out_user_d;

  // Per-channel views of the flattened input buses.
  logic [DATA_W-1:0]   ch_data [NUM_CH];
  logic [KEEP_W-1:0]   ch_keep [NUM_CH];
  logic [USER_W-1:0]   ch_user [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_data[gi] = s_axis_tx_tdata[gi*DATA_W +: DATA_W];
    assign ch_keep[gi] = s_axis_tx_tkeep[gi*KEEP_W +: KEEP_W];
    assign ch_user[gi] = s_axis_tx_tuser[gi*USER_W +: USER_W];
  end

  // Signals of the currently granted channel.
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;
  logic [USER_W-1:0]   sel_user;
  logic                sel_valid;
  logic                sel_last;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == CH_W'(c)) begin
        sel_data  = ch_data[c];
        sel_keep  = ch_keep[c];
        sel_user  = ch_user[c];
        sel_valid = s_axis_tx_tvalid[c];
        sel_last  = s_axis_tx_tlast[c];
      end
    end
  end

  // First requesting channel after 'last', wrapping modulo NUM_CH. The last
  // winner itself is searched last, which gives strict rotation under load.
  function automatic logic [CH_W-1:0] pick_winner(
    input logic [NUM_CH-1:0] req,
    input logic [CH_W-1:0]   last
  );
    logic [CH_W-1:0]   win;
    logic              found;
    logic [NUM_CH-1:0] shifted;
    int                idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx     = (int'(last) + k) % NUM_CH;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
    return win;
  endfunction

  logic                out_ready;
  logic                accept;
  logic [NUM_CH-1:0]   grant_onehot;

  assign grant_onehot = NUM_CH'(1) << grant_q;
  // The output stage can take a new beat when empty or being drained now.
  assign out_ready    = !out_valid_q || m_axis_tx_tready;

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    out_valid_d      = out_valid_q;
    out_last_d       = out_last_q;
    out_data_d       = out_data_q;
    out_keep_d       = out_keep_q;
    out_user_d       = out_user_q;
    s_axis_tx_tready = '0;
    accept           = 1'b0;

    // Drain: a handshake with no replacement beat empties the stage. Data
    // is left in place; only valid/last drop.
    if (out_valid_q && m_axis_tx_tready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (user_lnk_up && (|s_axis_tx_tvalid)) begin
          grant_d = pick_winner(s_axis_tx_tvalid, grant_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Link status is ignored here so an in-flight packet always finishes.
        if (out_ready) begin
          s_axis_tx_tready = grant_onehot;
        end
        accept = sel_valid && out_ready;
        if (accept) begin
          out_valid_d = 1'b1;
          out_last_d  = sel_last;
          out_data_d  = sel_data;
          out_keep_d  = sel_keep;
          out_user_d  = sel_user;
          if (sel_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      // Parked on the last channel so channel 0 wins the first arbitration.
      grant_q     <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_user_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_user_q  <= out_user_d;
    end
  end

  assign m_axis_tx_tdata  = out_data_q;
  assign m_axis_tx_tkeep  = out_keep_q;
  assign m_axis_tx_tuser  = out_user_q;
  assign m_axis_tx_tlast  = out_last_q;
  assign m_axis_tx_tvalid = out_valid_q;
  assign grant_id         = grant_q;
  assign busy             = (state_q == ST_BUSY);

`ifdef PCIE_TX_ARB_PKT_CNT_EN
  // A packet counts as sent once its tlast beat is taken from the source.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (accept && sel_last && (grant_q == CH_W'(gi))) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge sys_clk_n) begin
      if (!sys_rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pkt_cnt[gi*16 +: 16] = cnt_q;
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule
